// File: rtl/comparator_2bit.sv
// Registered 2-bit unsigned magnitude comparator with one-hot result flags
// and three saturating result counters (greater / less / equal).

module comparator_2bit_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Clear wins over a same-edge increment; a full counter holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (clr)                     cnt <= '0;
    else if (inc && (cnt != '1))      cnt <= cnt + CNT_W'(1);
  end

endmodule

module comparator_2bit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic             g2,
  output logic             l2,
  output logic             e2,
  output logic             out_valid,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt
);

  localparam int NUM_RES = 3;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

  cmp_res_t res_nxt, res_q;
  logic     vld_q;

  logic [NUM_RES-1:0]            cnt_inc;
  logic [NUM_RES-1:0][CNT_W-1:0] cnt_q;

  always_comb begin
    res_nxt    = '0;
    res_nxt.gt = (a > b);
    res_nxt.lt = (a < b);
    res_nxt.eq = (a == b);
  end

  // Result flags only move on an accepted compare; otherwise they hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) res_q <= res_nxt;
    end
  end

  // Gate with in_valid so unknown operands on idle cycles never reach a counter.
  assign cnt_inc = {NUM_RES{in_valid}} & {res_nxt.gt, res_nxt.lt, res_nxt.eq};

  for (genvar gi = 0; gi < NUM_RES; gi++) begin : g_cnt
    comparator_2bit_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc[gi]),
      .cnt (cnt_q[gi])
    );
  end

  assign g2        = res_q.gt;
  assign l2        = res_q.lt;
  assign e2        = res_q.eq;
  assign out_valid = vld_q;
  assign gt_cnt    = cnt_q[2];
  assign lt_cnt    = cnt_q[1];
  assign eq_cnt    = cnt_q[0];

endmodule

// File: tb/tb_comparator_2bit.sv
// Randomized and directed bench for comparator_2bit; two instances (CNT_W=8
// and CNT_W=2) share stimulus so saturation is exercised continuously.

module tb_comparator_2bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] a, b;
  logic       in_valid, cnt_clr;

  logic       g2, l2, e2, out_valid;
  logic [7:0] gt_cnt, lt_cnt, eq_cnt;
  logic       g2_s, l2_s, e2_s, out_valid_s;
  logic [1:0] gt_cnt_s, lt_cnt_s, eq_cnt_s;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: result flags, valid, and counts for both widths.
  logic m_g, m_l, m_e, m_ov;
  int   m_cnt  [3];   // 0=gt 1=lt 2=eq, saturates at 255
  int   m_cnt2 [3];   // saturates at 3

  always #5 clk = ~clk;

  comparator_2bit #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .g2(g2), .l2(l2), .e2(e2), .out_valid(out_valid),
    .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt)
  );

  comparator_2bit #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .g2(g2_s), .l2(l2_s), .e2(e2_s), .out_valid(out_valid_s),
    .gt_cnt(gt_cnt_s), .lt_cnt(lt_cnt_s), .eq_cnt(eq_cnt_s)
  );

  task automatic model_zero();
    m_g = 0; m_l = 0; m_e = 0; m_ov = 0;
    for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_cnt2[i] = 0; end
  endtask

  // Drive one cycle of stimulus at negedge, advance the model at posedge,
  // return shortly after the edge so callers sample settled outputs.
  task automatic step(input logic [1:0] ta, input logic [1:0] tb_, input logic tv, input logic tclr);
    int av, bv, idx;
    @(negedge clk);
    a = ta; b = tb_; in_valid = tv; cnt_clr = tclr;
    @(posedge clk);
    m_ov = tv;
    if (tv) begin
      av = int'(ta); bv = int'(tb_);
      m_g = (av > bv); m_l = (av < bv); m_e = (av == bv);
      idx = (av > bv) ? 0 : ((av < bv) ? 1 : 2);
    end else idx = -1;
    if (tclr) begin
      for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_cnt2[i] = 0; end
    end else if (idx >= 0) begin
      m_cnt[idx]  = (m_cnt[idx]  + 1 > 255) ? 255 : m_cnt[idx]  + 1;
      m_cnt2[idx] = (m_cnt2[idx] + 1 > 3)   ? 3   : m_cnt2[idx] + 1;
    end
    #2;
  endtask

  task automatic test_reset();
    rst = 1; a = 0; b = 0; in_valid = 0; cnt_clr = 0;
    model_zero();
    #12;
    n_chk++;
    if ({g2, l2, e2, out_valid, gt_cnt, lt_cnt, eq_cnt} !== 28'h0)
      $display("FAIL reset_state: got %b%b%b ov=%b cnt=%0d/%0d/%0d want all 0",
               g2, l2, e2, out_valid, gt_cnt, lt_cnt, eq_cnt);
    else n_pass++;
    // Valid input present on the edge where reset releases must be dropped.
    @(negedge clk); a = 2'b11; b = 2'b00; in_valid = 1;
    @(posedge clk); #1 rst = 0;
    #1;
    n_chk++;
    if ({g2, l2, e2, out_valid, gt_cnt} !== 12'h0)
      $display("FAIL reset_release_edge: got g=%b ov=%b gt=%0d want 0", g2, out_valid, gt_cnt);
    else n_pass++;
    step(2'b11, 2'b00, 1, 0);
    n_chk++;
    if ({g2, l2, e2, out_valid, gt_cnt} !== {4'b1001, 8'd1})
      $display("FAIL first_accept: got %b%b%b ov=%b gt=%0d want 100 ov=1 gt=1",
               g2, l2, e2, out_valid, gt_cnt);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [1:0] sa [5] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b10};
    logic [1:0] sb [5] = '{2'b11, 2'b00, 2'b10, 2'b00, 2'b01};
    logic [2:0] sr [5] = '{3'b001, 3'b100, 3'b001, 3'b001, 3'b100};
    step(2'b00, 2'b00, 0, 1);
    step(2'b00, 2'b10, 1, 0);
    n_chk++;
    if ({g2, l2, e2, out_valid, lt_cnt} !== {4'b0101, 8'd1})
      $display("FAIL less_than: got %b%b%b ov=%b lt=%0d want 010 ov=1 lt=1",
               g2, l2, e2, out_valid, lt_cnt);
    else n_pass++;
    step(2'b00, 2'b00, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(sa[i], sb[i], 1, 0);
      n_chk++;
      if ({g2, l2, e2, out_valid} !== {sr[i], 1'b1})
        $display("FAIL stream_%0d: got gle=%b%b%b ov=%b want gle=%b ov=1",
                 i, g2, l2, e2, out_valid, sr[i]);
      else n_pass++;
    end
    n_chk++;
    if ({eq_cnt, gt_cnt, lt_cnt} !== {8'd3, 8'd2, 8'd0})
      $display("FAIL stream_counts: got eq=%0d gt=%0d lt=%0d want 3 2 0", eq_cnt, gt_cnt, lt_cnt);
    else n_pass++;
    // 10 vs 01 must be greater; a signed view would say less.
    step(2'b10, 2'b01, 1, 0);
    n_chk++;
    if ({g2, l2, e2} !== 3'b100)
      $display("FAIL unsigned_cmp: got gle=%b%b%b want 100", g2, l2, e2);
    else n_pass++;
    // Hold: idle cycles with unknown operands leave flags and counts alone.
    step(2'bxx, 2'bxx, 0, 0);
    n_chk++;
    if ({g2, l2, e2, out_valid, gt_cnt} !== {4'b1000, 8'd3})
      $display("FAIL idle_hold: got gle=%b%b%b ov=%b gt=%0d want 100 ov=0 gt=3",
               g2, l2, e2, out_valid, gt_cnt);
    else n_pass++;
  endtask

  task automatic test_saturate();
    int seq [5] = '{1, 2, 3, 3, 3};
    step(2'b00, 2'b00, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(2'(i % 4), 2'(i % 4), 1, 0);
      n_chk++;
      if (int'(eq_cnt_s) !== seq[i] || int'(eq_cnt) !== i + 1)
        $display("FAIL saturate_%0d: got eq2=%0d eq8=%0d want %0d %0d",
                 i, eq_cnt_s, eq_cnt, seq[i], i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_clr_priority();
    step(2'b01, 2'b10, 1, 0);
    step(2'b11, 2'b01, 1, 1);
    n_chk++;
    if ({gt_cnt, lt_cnt, eq_cnt, gt_cnt_s, lt_cnt_s, eq_cnt_s} !== 30'h0 ||
        {g2, l2, e2, out_valid} !== 4'b1001)
      $display("FAIL clr_priority: got cnt=%0d/%0d/%0d gle=%b%b%b ov=%b want 0/0/0 100 ov=1",
               gt_cnt, lt_cnt, eq_cnt, g2, l2, e2, out_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] ra, rb;
    logic       rv, rc;
    int         errs = 0;
    for (int i = 0; i < 300; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 40) == 0);
      ra = rv ? 2'($urandom) : ((i % 2) ? 2'bxx : 2'($urandom));
      rb = rv ? 2'($urandom) : ((i % 3) ? 2'bxx : 2'($urandom));
      step(ra, rb, rv, rc);
      n_chk++;
      if ({g2, l2, e2, out_valid} !== {m_g, m_l, m_e, m_ov} ||
          {g2_s, l2_s, e2_s, out_valid_s} !== {m_g, m_l, m_e, m_ov} ||
          int'(gt_cnt) !== m_cnt[0] || int'(lt_cnt) !== m_cnt[1] || int'(eq_cnt) !== m_cnt[2] ||
          int'(gt_cnt_s) !== m_cnt2[0] || int'(lt_cnt_s) !== m_cnt2[1] || int'(eq_cnt_s) !== m_cnt2[2]) begin
        if (errs < 10)
          $display("FAIL random_%0d: got gle=%b%b%b ov=%b cnt=%0d/%0d/%0d cnt2=%0d/%0d/%0d want gle=%b%b%b ov=%b cnt=%0d/%0d/%0d cnt2=%0d/%0d/%0d",
                   i, g2, l2, e2, out_valid, gt_cnt, lt_cnt, eq_cnt, gt_cnt_s, lt_cnt_s, eq_cnt_s,
                   m_g, m_l, m_e, m_ov, m_cnt[0], m_cnt[1], m_cnt[2], m_cnt2[0], m_cnt2[1], m_cnt2[2]);
        errs++;
      end else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    step(2'b10, 2'b01, 1, 0);
    step(2'b01, 2'b01, 1, 0);
    #1 rst = 1;
    #1;
    n_chk++;
    if ({g2, l2, e2, out_valid, gt_cnt, lt_cnt, eq_cnt} !== 28'h0)
      $display("FAIL async_reset: got gle=%b%b%b ov=%b cnt=%0d/%0d/%0d want all 0",
               g2, l2, e2, out_valid, gt_cnt, lt_cnt, eq_cnt);
    else n_pass++;
    @(negedge clk); in_valid = 0; cnt_clr = 0; rst = 0;
    model_zero();
    @(posedge clk); @(posedge clk); #1;
    n_chk++;
    if ({g2, l2, e2, out_valid, gt_cnt, lt_cnt, eq_cnt} !== 28'h0 ||
        {g2_s, l2_s, e2_s, out_valid_s} !== 4'h0)
      $display("FAIL post_reset_idle: got gle=%b%b%b ov=%b cnt=%0d/%0d/%0d want all 0",
               g2, l2, e2, out_valid, gt_cnt, lt_cnt, eq_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_saturate();
    test_clr_priority();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
